regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-002 SHALL have wb_rd (in, 5): writeback destination register from the WB stage.
REQ-003 SHALL have wb_data (in, 32): writeback value.
REQ-004 SHALL have wb_regwen (in, 1): writeback write enable.
REQ-005 SHALL have wb_release (in, 1): WB retires one issued instruction whose rd is wb_rd; asserted for squashed instructions too, with wb_regwen low.
REQ-006 SHALL have rs1_addr, rs2_addr (in, 5 each): decode-stage source register addresses.
REQ-007 SHALL have rs1_data, rs2_data (out, 32 each): source operand values.
REQ-008 SHALL have issue_valid (in, 1), issue_regwrite (in, 1), issue_rd (in, 5): decode is issuing an instruction that will write issue_rd.
REQ-009 SHALL have rs1_busy, rs2_busy (out, 1 each) and stall (out, 1): hazard outputs to decode.

Function
REQ-010 SHALL hold 32 x 32-bit registers; x0 SHALL read as 0 at all times and SHALL never be written.
REQ-011 Write: at posedge clk, if wb_regwen and wb_rd != 0, regs[wb_rd] <= wb_data.
REQ-012 Read: combinational, zero latency; rsN_data = 0 if rsN_addr == 0.
REQ-013 Otherwise rsN_data = wb_data if wb_regwen and wb_rd == rsN_addr (same-cycle write-through bypass).
REQ-014 Otherwise rsN_data = regs[rsN_addr].
REQ-015 SHALL keep a 2-bit pending counter per register 1..31; pend[0] SHALL be constant 0.
REQ-016 inc[r] = issue_valid & issue_regwrite & !stall & issue_rd == r & r != 0.
REQ-017 dec[r] = wb_release & wb_rd == r & r != 0 & pend[r] != 0.
REQ-018 At posedge: inc only -> pend+1; dec only -> pend-1; both or neither -> unchanged.
REQ-019 A release to a register whose counter is 0 SHALL be ignored; the counter SHALL never underflow.
REQ-020 rsN_busy = (pend[rsN_addr] != 0) unless pend == 1 and wb_release & wb_regwen & wb_rd == rsN_addr, in which case it is 0 because the bypass covers the value.
REQ-021 rsN_busy SHALL be 0 for address 0.
REQ-022 stall = issue_valid & (rs1_busy | rs2_busy | (issue_regwrite & issue_rd != 0 & pend[issue_rd] == 3 & !dec[issue_rd])).
REQ-023 The counter SHALL never wrap from 3 to 0 and SHALL never exceed 3.
REQ-024 rsN_busy and stall SHALL be purely combinational from current inputs and state.
REQ-025 The block SHALL NOT know which source operands are used; decode SHALL mask rs1_busy and rs2_busy for unused operands before using them.

Reset
REQ-026 While rst = 1, all regs[1..31] and all pend counters SHALL be 0, asynchronously.
REQ-027 While rst = 1, the outputs SHALL be: rsN_data = 0 unless the bypass is active; rsN_busy = 0; stall = 0 unless issue_valid.
REQ-028 No write and no counter update SHALL occur on a clock edge while rst = 1.
REQ-029 Deassertion of rst mid-operation SHALL take effect on the next posedge, with all state cleared.

Verification
REQ-030 Write/read: wb_rd=5, wb_data=0x12345678, wb_regwen=1, rs1_addr=5 -> rs1_data=0x12345678 in the same cycle (bypass) and in the next cycle (array).
REQ-031 x0: wb_rd=0, wb_regwen=1, wb_data=0xFFFFFFFF; rs2_addr=0 -> rs2_data=0 in that cycle and after; pend[0] stays 0 with issue_rd=0.
REQ-032 Load-use: issue rd=7 (cycle 0); cycle 1 rs1_addr=7 -> rs1_busy=1, stall=1; cycle 3 wb_release=1, wb_regwen=1, wb_rd=7 -> rs1_busy=0, stall=0, bypass data; cycle 4 -> pend[7]=0.
REQ-033 Saturation: three issues to rd=9 with no release -> pend[9]=3; a fourth issue -> stall=1, counter stays 3; the same issue with a simultaneous release of rd=9 -> stall=0, counter stays 3.
REQ-034 Squash: pend[4]=1; wb_release=1, wb_regwen=0, wb_rd=4 -> rs1_busy(4)=1 that cycle (no bypass), pend[4]=0 next cycle, regs[4] unchanged.
REQ-035 Reset mid-operation: pend[3]=2 and regs[3]=0xA5; assert rst between clock edges -> pend[3]=0 and rs1_data(3)=0 immediately; no write on following edges until rst=0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register file / scoreboard bus: writeback, decode read ports, issue and hazard signals.
// The master side is the pipeline (WB + decode); the slave side is regfile_sb.
interface regfile_sb_if #(
  parameter int DATA_W = 32
);
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_regwen;
  logic              wb_release;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              issue_valid;
  logic              issue_regwrite;
  logic [4:0]        issue_rd;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              stall;

  modport master (
    output wb_rd, wb_data, wb_regwen, wb_release,
    output rs1_addr, rs2_addr, issue_valid, issue_regwrite, issue_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall
  );

  modport slave (
    input  wb_rd, wb_data, wb_regwen, wb_release,
    input  rs1_addr, rs2_addr, issue_valid, issue_regwrite, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, stall
  );
endinterface

// File: rtl/regfile_sb.sv
// 32x32 register file with write-through bypass and a 2-bit pending-write
// scoreboard per register that drives operand-busy and issue-stall hazards.
module regfile_sb #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  // Entry 0 of both arrays is cleared by reset and never written afterwards.
  logic [DATA_W-1:0] regs [32];
  logic [1:0]        pend [32];

  logic [31:0] inc;
  logic [31:0] dec;
  logic [1:0]  pend_rs1, pend_rs2, pend_ird;
  logic        dec_ird;
  logic        byp_rel1, byp_rel2;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < 32; r++) begin
      inc[r] = bus.issue_valid && bus.issue_regwrite && !bus.stall &&
               (bus.issue_rd == 5'(r));
      dec[r] = bus.wb_release && (bus.wb_rd == 5'(r)) && (pend[r] != 2'd0);
    end
  end

  always_comb begin
    pend_rs1 = (bus.rs1_addr == 5'd0) ? 2'd0 : pend[bus.rs1_addr];
    pend_rs2 = (bus.rs2_addr == 5'd0) ? 2'd0 : pend[bus.rs2_addr];
    pend_ird = (bus.issue_rd == 5'd0) ? 2'd0 : pend[bus.issue_rd];
    dec_ird  = dec[bus.issue_rd];

    if (bus.rs1_addr == 5'd0)
      bus.rs1_data = '0;
    else if (bus.wb_regwen && bus.wb_rd == bus.rs1_addr)
      bus.rs1_data = bus.wb_data;
    else
      bus.rs1_data = regs[bus.rs1_addr];

    if (bus.rs2_addr == 5'd0)
      bus.rs2_data = '0;
    else if (bus.wb_regwen && bus.wb_rd == bus.rs2_addr)
      bus.rs2_data = bus.wb_data;
    else
      bus.rs2_data = regs[bus.rs2_addr];

    // A last outstanding write retiring this cycle is covered by the bypass.
    byp_rel1 = bus.wb_release && bus.wb_regwen && (bus.wb_rd == bus.rs1_addr);
    byp_rel2 = bus.wb_release && bus.wb_regwen && (bus.wb_rd == bus.rs2_addr);
    bus.rs1_busy = (pend_rs1 != 2'd0) && !((pend_rs1 == 2'd1) && byp_rel1);
    bus.rs2_busy = (pend_rs2 != 2'd0) && !((pend_rs2 == 2'd1) && byp_rel2);

    // Saturated counter blocks a new issue unless a release frees a slot now.
    bus.stall = bus.issue_valid &&
                (bus.rs1_busy || bus.rs2_busy ||
                 (bus.issue_regwrite && (bus.issue_rd != 5'd0) &&
                  (pend_ird == 2'd3) && !dec_ird));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= '0;
        pend[r] <= 2'd0;
      end
    end else begin
      if (bus.wb_regwen && bus.wb_rd != 5'd0)
        regs[bus.wb_rd] <= bus.wb_data;
      for (int r = 1; r < 32; r++) begin
        if (inc[r] && !dec[r])
          pend[r] <= pend[r] + 2'd1;
        else if (dec[r] && !inc[r])
          pend[r] <= pend[r] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: table of single-cycle vectors plus
// hand-written saturation and mid-operation reset sequences.
module tb_regfile_sb;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_sb_if #(.DATA_W(32)) bus ();

  regfile_sb #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        regwen;
    logic        release_;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iv;
    logic        irw;
    logic [4:0]  ird;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic        e_st;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic [4:0] wb_rd, input logic [31:0] wb_data,
                              input logic regwen, input logic rel,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic iv, input logic irw, input logic [4:0] ird,
                              input logic [31:0] e_d1, input logic [31:0] e_d2,
                              input logic e_b1, input logic e_b2, input logic e_st);
    vec_t v;
    v.wb_rd = wb_rd; v.wb_data = wb_data; v.regwen = regwen; v.release_ = rel;
    v.rs1 = rs1; v.rs2 = rs2; v.iv = iv; v.irw = irw; v.ird = ird;
    v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_st = e_st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] wb_rd, input logic [31:0] wb_data,
                       input logic regwen, input logic rel,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic iv, input logic irw, input logic [4:0] ird);
    bus.wb_rd = wb_rd; bus.wb_data = wb_data; bus.wb_regwen = regwen;
    bus.wb_release = rel; bus.rs1_addr = rs1; bus.rs2_addr = rs2;
    bus.issue_valid = iv; bus.issue_regwrite = irw; bus.issue_rd = ird;
  endtask

  task automatic idle();
    drive(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = mk(5'd5, 32'h12345678, 1, 0, 5'd5, 5'd0, 0, 0, 5'd0, 32'h12345678, 32'h0, 0, 0, 0);
    vecs[1]  = mk(5'd0, 32'h0,        0, 0, 5'd5, 5'd5, 0, 0, 5'd0, 32'h12345678, 32'h12345678, 0, 0, 0);
    vecs[2]  = mk(5'd0, 32'hFFFFFFFF, 1, 0, 5'd0, 5'd0, 1, 1, 5'd0, 32'h0, 32'h0, 0, 0, 0);
    vecs[3]  = mk(5'd0, 32'h0,        0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0);
    vecs[4]  = mk(5'd4, 32'h00000044, 1, 0, 5'd0, 5'd4, 1, 1, 5'd7, 32'h0, 32'h44, 0, 0, 0);
    vecs[5]  = mk(5'd0, 32'h0,        0, 0, 5'd7, 5'd0, 1, 0, 5'd0, 32'h0, 32'h0, 1, 0, 1);
    vecs[6]  = mk(5'd0, 32'h0,        0, 0, 5'd7, 5'd0, 1, 0, 5'd0, 32'h0, 32'h0, 1, 0, 1);
    vecs[7]  = mk(5'd7, 32'hDEADBEEF, 1, 1, 5'd7, 5'd0, 1, 0, 5'd0, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    vecs[8]  = mk(5'd0, 32'h0,        0, 0, 5'd7, 5'd4, 0, 0, 5'd0, 32'hDEADBEEF, 32'h44, 0, 0, 0);
    vecs[9]  = mk(5'd0, 32'h0,        0, 0, 5'd0, 5'd0, 1, 1, 5'd4, 32'h0, 32'h0, 0, 0, 0);
    vecs[10] = mk(5'd4, 32'h00000099, 0, 1, 5'd4, 5'd4, 0, 0, 5'd0, 32'h44, 32'h44, 1, 1, 0);
    vecs[11] = mk(5'd0, 32'h0,        0, 0, 5'd4, 5'd0, 0, 0, 5'd0, 32'h44, 32'h0, 0, 0, 0);
    vecs[12] = mk(5'd4, 32'h0,        0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0);
    vecs[13] = mk(5'd0, 32'h0,        0, 0, 5'd0, 5'd0, 1, 1, 5'd4, 32'h0, 32'h0, 0, 0, 0);
    vecs[14] = mk(5'd0, 32'h0,        0, 0, 5'd4, 5'd0, 0, 0, 5'd0, 32'h44, 32'h0, 1, 0, 0);
    vecs[15] = mk(5'd4, 32'h00000055, 1, 1, 5'd0, 5'd4, 0, 0, 5'd0, 32'h0, 32'h55, 0, 0, 0);
    vecs[16] = mk(5'd0, 32'h0,        0, 0, 5'd0, 5'd4, 0, 0, 5'd0, 32'h0, 32'h55, 0, 0, 0);
    vecs[17] = mk(5'd0, 32'h0,        0, 0, 5'd0, 5'd0, 1, 1, 5'd8, 32'h0, 32'h0, 0, 0, 0);
    vecs[18] = mk(5'd0, 32'h0,        0, 0, 5'd0, 5'd8, 1, 1, 5'd10, 32'h0, 32'h0, 0, 1, 1);
    vecs[19] = mk(5'd8, 32'h0,        0, 1, 5'd8, 5'd10, 0, 0, 5'd0, 32'h0, 32'h0, 1, 0, 0);
    vecs[20] = mk(5'd0, 32'h0,        0, 0, 5'd8, 5'd10, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0);

    // Reset state
    rst = 1'b1;
    drive(5'd0, 32'h0, 1'b0, 1'b0, 5'd5, 5'd31, 1'b0, 1'b0, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_rs1_data", bus.rs1_data, 32'h0);
    check("reset_rs2_data", bus.rs2_data, 32'h0);
    check("reset_rs1_busy", 32'(bus.rs1_busy), 32'h0);
    check("reset_stall",    32'(bus.stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i].wb_rd, vecs[i].wb_data, vecs[i].regwen, vecs[i].release_,
            vecs[i].rs1, vecs[i].rs2, vecs[i].iv, vecs[i].irw, vecs[i].ird);
      #1;
      check($sformatf("v%0d_rs1_data", i), bus.rs1_data, vecs[i].e_d1);
      check($sformatf("v%0d_rs2_data", i), bus.rs2_data, vecs[i].e_d2);
      check($sformatf("v%0d_rs1_busy", i), 32'(bus.rs1_busy), 32'(vecs[i].e_b1));
      check($sformatf("v%0d_rs2_busy", i), 32'(bus.rs2_busy), 32'(vecs[i].e_b2));
      check($sformatf("v%0d_stall", i),    32'(bus.stall), 32'(vecs[i].e_st));
    end

    // Saturation on rd=9
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9);
      #1;
      check($sformatf("sat_issue%0d_stall", k), 32'(bus.stall), 32'h0);
    end
    @(negedge clk);
    drive(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9);
    #1;
    check("sat_full_stall", 32'(bus.stall), 32'h1);
    @(negedge clk);
    drive(5'd9, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9);
    #1;
    check("sat_release_issue_stall", 32'(bus.stall), 32'h0);
    // Counter must still be 3: three more releases are needed to clear it.
    @(negedge clk);
    drive(5'd9, 32'h0, 1'b0, 1'b1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("sat_p3_busy", 32'(bus.rs1_busy), 32'h1);
    @(negedge clk);
    drive(5'd9, 32'h00000909, 1'b1, 1'b1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("sat_p2_rel_busy", 32'(bus.rs1_busy), 32'h1);
    check("sat_p2_bypass",   bus.rs1_data, 32'h00000909);
    @(negedge clk);
    drive(5'd9, 32'h00000999, 1'b1, 1'b1, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("sat_p1_rel_busy", 32'(bus.rs1_busy), 32'h0);
    @(negedge clk);
    drive(5'd0, 32'h0, 1'b0, 1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("sat_p0_busy", 32'(bus.rs1_busy), 32'h0);
    check("sat_p0_data", bus.rs1_data, 32'h00000999);

    // Reset mid-operation: regs[3]=0xA5, pend[3]=2
    @(negedge clk);
    drive(5'd3, 32'h000000A5, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3);
    @(negedge clk);
    drive(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3);
    @(negedge clk);
    drive(5'd0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("pre_rst_data", bus.rs1_data, 32'h000000A5);
    check("pre_rst_busy", 32'(bus.rs1_busy), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_data", bus.rs1_data, 32'h0);
    check("rst_async_busy", 32'(bus.rs1_busy), 32'h0);
    @(negedge clk);
    drive(5'd3, 32'h00000077, 1'b1, 1'b0, 5'd3, 5'd0, 1'b1, 1'b1, 5'd3);
    #1;
    check("rst_bypass_data", bus.rs1_data, 32'h00000077);
    @(negedge clk);
    drive(5'd0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("rst_no_write_data", bus.rs1_data, 32'h0);
    check("rst_no_inc_busy",   32'(bus.rs1_busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_data", bus.rs1_data, 32'h0);
    check("post_rst_busy", 32'(bus.rs1_busy), 32'h0);
    idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
